// File: rtl/video_cfg_sequencer.sv
// AXI4-Lite master that writes a shadowed (addr,data) table into videoProcess.
// Define VIDEO_CFG_READBACK_EN to read back and verify every entry afterwards.
module video_cfg_sequencer #(
  parameter int ADDR_WIDTH  = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_ENTRIES = 4
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic                    start,
  input  logic [NUM_ENTRIES*(ADDR_WIDTH+DATA_WIDTH)-1:0] cfg_table,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [$clog2(NUM_ENTRIES):0] err_index,
  output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]              M_AXI_AWPROT,
  output logic                    M_AXI_AWVALID,
  input  logic                    M_AXI_AWREADY,
  output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                    M_AXI_WVALID,
  input  logic                    M_AXI_WREADY,
  input  logic [1:0]              M_AXI_BRESP,
  input  logic                    M_AXI_BVALID,
  output logic                    M_AXI_BREADY,
  output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]              M_AXI_ARPROT,
  output logic                    M_AXI_ARVALID,
  input  logic                    M_AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]              M_AXI_RRESP,
  input  logic                    M_AXI_RVALID,
  output logic                    M_AXI_RREADY
);

  localparam int EW = ADDR_WIDTH + DATA_WIDTH;
  localparam int IW = $clog2(NUM_ENTRIES) + 1;
  localparam int SW = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

`ifdef VIDEO_CFG_READBACK_EN
  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_WR_RESP, S_RD, S_RD_DATA, S_FIN
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE, S_WR, S_WR_RESP, S_FIN
  } state_t;
`endif

  state_t                r_state, w_state_nx;
  logic [EW-1:0]         r_shadow [NUM_ENTRIES];
  logic [IW-1:0]         r_idx, w_idx_nx;
  logic                  r_busy, w_busy_nx;
  logic                  r_done, w_done_nx;
  logic                  r_error, w_error_nx;
  logic [IW-1:0]         r_eidx, w_eidx_nx;
  logic [ADDR_WIDTH-1:0] r_awaddr, w_awaddr_nx;
  logic                  r_awvalid, w_awvalid_nx;
  logic [DATA_WIDTH-1:0] r_wdata, w_wdata_nx;
  logic                  r_wvalid, w_wvalid_nx;
  logic                  r_bready, w_bready_nx;
  logic                  r_issued, w_issued_nx;
  logic                  w_load;
  logic [SW-1:0]         w_sel;
  logic [ADDR_WIDTH-1:0] w_ent_addr;
  logic [DATA_WIDTH-1:0] w_ent_data;
  logic                  w_last;
`ifdef VIDEO_CFG_READBACK_EN
  logic [ADDR_WIDTH-1:0] r_araddr, w_araddr_nx;
  logic                  r_arvalid, w_arvalid_nx;
  logic                  r_rready, w_rready_nx;
`endif

  assign w_sel      = r_idx[SW-1:0];
  assign w_ent_addr = r_shadow[w_sel][EW-1:DATA_WIDTH];
  assign w_ent_data = r_shadow[w_sel][DATA_WIDTH-1:0];
  assign w_last     = (r_idx == IW'(NUM_ENTRIES - 1));

  always_comb begin
    w_state_nx   = r_state;
    w_idx_nx     = r_idx;
    w_busy_nx    = r_busy;
    w_done_nx    = r_done;
    w_error_nx   = r_error;
    w_eidx_nx    = r_eidx;
    w_awaddr_nx  = r_awaddr;
    w_awvalid_nx = r_awvalid;
    w_wdata_nx   = r_wdata;
    w_wvalid_nx  = r_wvalid;
    w_bready_nx  = r_bready;
    w_issued_nx  = r_issued;
    w_load       = 1'b0;
`ifdef VIDEO_CFG_READBACK_EN
    w_araddr_nx  = r_araddr;
    w_arvalid_nx = r_arvalid;
    w_rready_nx  = r_rready;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_load     = 1'b1;
          w_idx_nx   = '0;
          w_done_nx  = 1'b0;
          w_error_nx = 1'b0;
          w_eidx_nx  = '1;
          w_busy_nx  = 1'b1;
          w_state_nx = S_WR;
        end
      end
      S_WR: begin
        if (!r_issued) begin
          w_issued_nx  = 1'b1;
          w_awvalid_nx = 1'b1;
          w_wvalid_nx  = 1'b1;
          w_awaddr_nx  = w_ent_addr;
          w_wdata_nx   = w_ent_data;
        end else begin
          // each channel retires on its own handshake
          w_awvalid_nx = r_awvalid & ~M_AXI_AWREADY;
          w_wvalid_nx  = r_wvalid & ~M_AXI_WREADY;
          if ((!r_awvalid || M_AXI_AWREADY) &&
              (!r_wvalid || M_AXI_WREADY)) begin
            w_issued_nx = 1'b0;
            w_bready_nx = 1'b1;
            w_state_nx  = S_WR_RESP;
          end
        end
      end
      S_WR_RESP: begin
        if (M_AXI_BVALID) begin
          w_bready_nx = 1'b0;
          if (M_AXI_BRESP != 2'b00) begin
            w_eidx_nx  = r_idx;
            w_error_nx = 1'b1;
            w_state_nx = S_FIN;
          end else if (w_last) begin
`ifdef VIDEO_CFG_READBACK_EN
            w_idx_nx   = '0;
            w_state_nx = S_RD;
`else
            w_state_nx = S_FIN;
`endif
          end else begin
            w_idx_nx   = r_idx + 1'b1;
            w_state_nx = S_WR;
          end
        end
      end
`ifdef VIDEO_CFG_READBACK_EN
      S_RD: begin
        if (!r_issued) begin
          w_issued_nx  = 1'b1;
          w_arvalid_nx = 1'b1;
          w_araddr_nx  = w_ent_addr;
        end else if (M_AXI_ARREADY) begin
          w_issued_nx  = 1'b0;
          w_arvalid_nx = 1'b0;
          w_rready_nx  = 1'b1;
          w_state_nx   = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        if (M_AXI_RVALID) begin
          w_rready_nx = 1'b0;
          if (M_AXI_RRESP != 2'b00 ||
              M_AXI_RDATA != w_ent_data) begin
            w_eidx_nx  = r_idx;
            w_error_nx = 1'b1;
            w_state_nx = S_FIN;
          end else if (w_last) begin
            w_state_nx = S_FIN;
          end else begin
            w_idx_nx   = r_idx + 1'b1;
            w_state_nx = S_RD;
          end
        end
      end
`endif
      S_FIN: begin
        w_busy_nx  = 1'b0;
        w_done_nx  = 1'b1;
        w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
      r_eidx    <= '1;
      r_awaddr  <= '0;
      r_awvalid <= 1'b0;
      r_wdata   <= '0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_issued  <= 1'b0;
      for (int k = 0; k < NUM_ENTRIES; k++)
        r_shadow[k] <= '0;
`ifdef VIDEO_CFG_READBACK_EN
      r_araddr  <= '0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nx;
      r_idx     <= w_idx_nx;
      r_busy    <= w_busy_nx;
      r_done    <= w_done_nx;
      r_error   <= w_error_nx;
      r_eidx    <= w_eidx_nx;
      r_awaddr  <= w_awaddr_nx;
      r_awvalid <= w_awvalid_nx;
      r_wdata   <= w_wdata_nx;
      r_wvalid  <= w_wvalid_nx;
      r_bready  <= w_bready_nx;
      r_issued  <= w_issued_nx;
      if (w_load)
        for (int k = 0; k < NUM_ENTRIES; k++)
          r_shadow[k] <= cfg_table[k*EW +: EW];
`ifdef VIDEO_CFG_READBACK_EN
      r_araddr  <= w_araddr_nx;
      r_arvalid <= w_arvalid_nx;
      r_rready  <= w_rready_nx;
`endif
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign error         = r_error;
  assign err_index     = r_eidx;
  assign M_AXI_AWADDR  = r_awaddr;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = r_awvalid;
  assign M_AXI_WDATA   = r_wdata;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WVALID  = r_wvalid;
  assign M_AXI_BREADY  = r_bready;
  assign M_AXI_ARPROT  = 3'b000;

`ifdef VIDEO_CFG_READBACK_EN
  assign M_AXI_ARADDR  = r_araddr;
  assign M_AXI_ARVALID = r_arvalid;
  assign M_AXI_RREADY  = r_rready;
`else
  assign M_AXI_ARADDR  = '0;
  assign M_AXI_ARVALID = 1'b0;
  assign M_AXI_RREADY  = 1'b0;

  logic w_unused;
  assign w_unused = ^{M_AXI_ARREADY, M_AXI_RDATA,
                      M_AXI_RRESP, M_AXI_RVALID};
`endif

endmodule

// File: tb/tb_video_cfg_sequencer.sv
// Scoreboard bench for video_cfg_sequencer with a randomizing AXI4-Lite slave.
// Follows VIDEO_CFG_READBACK_EN so the reference model matches the build.
module tb_video_cfg_sequencer;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int N  = 4;
  localparam int EW = AW + DW;
  localparam int TW = N * EW;
  localparam int IW = $clog2(N) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [TW-1:0] cfg_table = '0;
  logic          busy, done, error;
  logic [IW-1:0] err_index;
  logic [AW-1:0] AWADDR, ARADDR;
  logic [2:0]    AWPROT, ARPROT;
  logic          AWVALID, WVALID, BREADY, ARVALID, RREADY;
  logic [DW-1:0] WDATA;
  logic [3:0]    WSTRB;
  logic          awready = 0, wready = 0, arready = 0;
  logic          bvalid = 0, rvalid = 0;
  logic [1:0]    bresp = 0, rresp = 0;
  logic [DW-1:0] rdata = 0;

  video_cfg_sequencer #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_ENTRIES(N)
  ) dut (
    .ACLK(clk), .ARESETN(rst_n), .start(start),
    .cfg_table(cfg_table), .busy(busy), .done(done),
    .error(error), .err_index(err_index),
    .M_AXI_AWADDR(AWADDR), .M_AXI_AWPROT(AWPROT),
    .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB),
    .M_AXI_WVALID(WVALID), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid),
    .M_AXI_BREADY(BREADY), .M_AXI_ARADDR(ARADDR),
    .M_AXI_ARPROT(ARPROT), .M_AXI_ARVALID(ARVALID),
    .M_AXI_ARREADY(arready), .M_AXI_RDATA(rdata),
    .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid),
    .M_AXI_RREADY(RREADY)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm, input logic [63:0] act);
    total++;
    bad++;
    $display("FAIL %s: got %0h expected nothing", nm, act);
  endtask

  // scoreboard queues
  logic [AW-1:0] q_aw[$];
  logic [DW-1:0] q_w[$];
  logic [AW-1:0] q_ar[$];
  logic [IW:0]   q_res[$];

  // slave controls / shared status
  int  ready_mode = 0;
  int  bad_b = -1, bad_r = -1;
  int  wcnt = 0, rcnt = 0;
  int  aw_count = 0;
  bit  done_seen = 0;
  int  done_cyc = 0;

  // reference model: sequence of writes, then optional readback
  task automatic model(input logic [TW-1:0] tbl, input int bb,
                       input int br);
    logic [DW-1:0] m [4];
    logic [AW-1:0] a;
    logic [DW-1:0] d, rd;
    for (int k = 0; k < N; k++) begin
      a = tbl[k*EW+DW +: AW];
      d = tbl[k*EW +: DW];
      q_aw.push_back(a);
      q_w.push_back(d);
      m[a[3:2]] = d;
      if (k == bb) begin
        q_res.push_back({1'b1, IW'(k)});
        return;
      end
    end
`ifdef VIDEO_CFG_READBACK_EN
    for (int k = 0; k < N; k++) begin
      a = tbl[k*EW+DW +: AW];
      d = tbl[k*EW +: DW];
      q_ar.push_back(a);
      rd = m[a[3:2]];
      if (k == br) rd = rd ^ 32'h1;
      if (rd != d) begin
        q_res.push_back({1'b1, IW'(k)});
        return;
      end
    end
`endif
    q_res.push_back({1'b0, {IW{1'b1}}});
  endtask

  // AXI4-Lite slave: decisions at negedge take effect at next posedge
  initial begin
    logic [DW-1:0] mem [4];
    bit have_aw, have_w, p_aw, p_w, p_b, p_ar, p_r;
    logic [AW-1:0] aw_a, p_aw_addr, p_ar_addr;
    logic [DW-1:0] w_d, p_w_data;
    int aw_wait;
    have_aw = 0; have_w = 0; aw_wait = 0;
    p_aw = 0; p_w = 0; p_b = 0; p_ar = 0; p_r = 0;
    for (int i = 0; i < 4; i++) mem[i] = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        awready = 0; wready = 0; arready = 0;
        bvalid = 0; rvalid = 0;
        have_aw = 0; have_w = 0; aw_wait = 0;
        p_aw = 0; p_w = 0; p_b = 0; p_ar = 0; p_r = 0;
      end else begin
        if (p_b) bvalid = 0;
        if (p_r) rvalid = 0;
        if (p_aw) begin have_aw = 1; aw_a = p_aw_addr; end
        if (p_w) begin have_w = 1; w_d = p_w_data; end
        if (have_aw && have_w) begin
          mem[aw_a[3:2]] = w_d;
          bresp = (wcnt == bad_b) ? 2'b10 : 2'b00;
          wcnt++;
          bvalid = 1;
          have_aw = 0;
          have_w = 0;
        end
        if (p_ar) begin
          rdata = mem[p_ar_addr[3:2]];
          if (rcnt == bad_r) rdata = rdata ^ 32'h1;
          rcnt++;
          rresp = 2'b00;
          rvalid = 1;
        end
        case (ready_mode)
          0: begin awready = 1; wready = 1; arready = 1; end
          1: begin
            awready = ($urandom_range(0, 3) != 0);
            wready  = ($urandom_range(0, 3) != 0);
            arready = ($urandom_range(0, 3) != 0);
          end
          default: begin
            awready = (aw_wait >= 5); wready = 1; arready = 1;
          end
        endcase
        p_aw = AWVALID && awready; p_aw_addr = AWADDR;
        p_w  = WVALID && wready;   p_w_data  = WDATA;
        p_ar = ARVALID && arready; p_ar_addr = ARADDR;
        p_b  = bvalid && BREADY;
        p_r  = rvalid && RREADY;
        if (p_aw) aw_wait = 0;
        else if (AWVALID) aw_wait++;
      end
    end
  end

  // monitor: pops expectations whenever the DUT presents a transfer
  initial begin
    bit pend_aw, pend_w, pend_ar, prev_done;
    logic [AW-1:0] l_aw, l_ar;
    logic [DW-1:0] l_w;
    logic [IW:0] r;
    int aw_hi, w_hi;
    pend_aw = 0; pend_w = 0; pend_ar = 0; prev_done = 0;
    aw_hi = 0; w_hi = 0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        pend_aw = 0; pend_w = 0; pend_ar = 0; prev_done = 0;
        aw_hi = 0; w_hi = 0;
      end else begin
        if (pend_aw) check("aw_hold", {AWVALID, AWADDR}, {1'b1, l_aw});
        if (pend_w)  check("w_hold", {WVALID, WDATA}, {1'b1, l_w});
        if (pend_ar) check("ar_hold", {ARVALID, ARADDR}, {1'b1, l_ar});
        if (BREADY) check("bready_excl", {AWVALID, WVALID}, 2'b00);
        if (AWVALID) aw_hi++;
        if (WVALID) w_hi++;
        if (AWVALID && awready) begin
          if (q_aw.size() == 0) flag("aw_unexpected", AWADDR);
          else check("awaddr", AWADDR, q_aw.pop_front());
          if (ready_mode == 2) check("aw_valid_cycles", aw_hi, 6);
          aw_count++;
          aw_hi = 0;
        end
        if (WVALID && wready) begin
          if (q_w.size() == 0) flag("w_unexpected", WDATA);
          else check("wdata", WDATA, q_w.pop_front());
          if (ready_mode == 2) check("w_valid_cycles", w_hi, 1);
          w_hi = 0;
        end
        if (ARVALID && arready) begin
          if (q_ar.size() == 0) flag("ar_unexpected", ARADDR);
          else check("araddr", ARADDR, q_ar.pop_front());
        end
        pend_aw = AWVALID && !awready; l_aw = AWADDR;
        pend_w  = WVALID && !wready;   l_w  = WDATA;
        pend_ar = ARVALID && !arready; l_ar = ARADDR;
        if (done && !prev_done) begin
          if (q_res.size() == 0) flag("done_unexpected", {error, err_index});
          else begin
            r = q_res.pop_front();
            check("error", error, r[IW]);
            check("err_index", err_index, r[IW-1:0]);
            check("busy_at_done", busy, 0);
          end
          done_seen = 1;
          done_cyc = cyc;
        end
        prev_done = done;
      end
    end
  end

  task automatic flush();
    q_aw.delete(); q_w.delete(); q_ar.delete(); q_res.delete();
  endtask

  task automatic run(input logic [TW-1:0] tbl, input int bb,
                     input int br, input int mode, input bit poke);
    int s_cyc;
    model(tbl, bb, br);
    @(negedge clk);
    ready_mode = mode; bad_b = bb; bad_r = br;
    wcnt = 0; rcnt = 0; aw_count = 0; done_seen = 0;
    cfg_table = tbl;
    start = 1;
    s_cyc = cyc + 1;
    @(negedge clk);
    start = 0;
    if (poke) begin
      repeat (4) @(negedge clk);
      start = 1;
      cfg_table = {$urandom, $urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      start = 0;
    end
    for (int c = 0; c < 3000 && !done_seen; c++) @(negedge clk);
    #2;
    if (!done_seen) flag("done_timeout", busy);
    repeat (4) @(negedge clk);
    check("leftover_expect",
          q_aw.size() + q_w.size() + q_ar.size() + q_res.size(), 0);
`ifndef VIDEO_CFG_READBACK_EN
    if (mode == 0 && done_seen)
      check("done_latency", done_cyc - s_cyc,
            3 * ((bb < 0) ? N : bb + 1) + 1);
`endif
    flush();
  endtask

  function automatic logic [TW-1:0] seq_table();
    logic [TW-1:0] t;
    t = '0;
    for (int k = 0; k < N; k++)
      t[k*EW +: EW] = {AW'(k * 4), DW'(k + 1)};
    return t;
  endfunction

  initial begin
    logic [TW-1:0] t0, tr;
    int bb, br;
    bit found;
    t0 = seq_table();
    #23;
    check("rst_valids", {AWVALID, WVALID, BREADY, ARVALID, RREADY}, 0);
    check("rst_status", {busy, done, error}, 0);
    check("rst_err_index", err_index, {IW{1'b1}});
    check("rst_addr_data", {AWADDR, WDATA, ARADDR}, 0);
    check("const_prot_strb", {AWPROT, ARPROT, WSTRB}, 10'h00F);
    @(negedge clk);
    #3 rst_n = 1;

    run(t0, -1, -1, 0, 0);
    run(t0, -1, -1, 2, 0);
    run(t0, 2, -1, 0, 0);
`ifdef VIDEO_CFG_READBACK_EN
    run(t0, -1, 1, 0, 0);
`endif

    // asynchronous reset while entry 1 is on the AW channel
    model(t0, -1, -1);
    @(negedge clk);
    ready_mode = 0; bad_b = -1; bad_r = -1;
    wcnt = 0; rcnt = 0; aw_count = 0;
    cfg_table = t0;
    start = 1;
    @(negedge clk);
    start = 0;
    found = 0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk);
      #2;
      found = (aw_count >= 1) && AWVALID;
    end
    if (!found) flag("reset_trigger_timeout", aw_count);
    rst_n = 0;
    #1;
    check("arst_valids", {AWVALID, WVALID, BREADY}, 0);
    check("arst_status", {busy, done}, 0);
    flush();
    repeat (2) @(negedge clk);
    #3 rst_n = 1;
    run(t0, -1, -1, 0, 0);

    // restart attempt while busy plus table change mid-run
    run(t0, -1, -1, 0, 1);

    for (int i = 0; i < 25; i++) begin
      for (int k = 0; k < N; k++)
        tr[k*EW +: EW] = {AW'($urandom_range(0, 3) * 4), DW'($urandom)};
      bb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N-1)) : -1;
      br = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N-1)) : -1;
      run(tr, bb, br, int'($urandom_range(0, 2)),
          (bb < 0) && ($urandom_range(0, 1) == 1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/video_cfg_sequencer.md
Name: video_cfg_sequencer

Overview:
- AXI4-Lite master that sequences configuration of the videoProcess register file (S00_AXI, 4 x 32-bit registers at 0x0/0x4/0x8/0xC).
- On `start` it walks a configuration table of (address, data) entries and issues one single-beat write per entry.
- Optionally it reads every entry back and verifies it.
- Sits between the system control logic and the videoProcess slave port, replacing the bench-driven register programming in hardware.

Parameters:
- ADDR_WIDTH, 4, AXI4-Lite byte address width.
- DATA_WIDTH, 32, AXI4-Lite data width (fixed 32; other values unsupported).
- NUM_ENTRIES, 4, table depth; must be ≥1.

Ports:
- ACLK  in  1  clock.
- ARESETN  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a sequence when idle.
- cfg_table  in  NUM_ENTRIES*(ADDR_WIDTH+DATA_WIDTH)  entry k = {addr,data} at bits [k*(A+D) +: A+D]; data in LSBs.
- busy  out  1  sequence in progress.
- done  out  1  sequence finished; held until next accepted start.
- error  out  1  finished with failure; valid when done=1.
- err_index  out  clog2(NUM_ENTRIES)+1  index of first failing entry; all-ones when no error.
- M_AXI_AWADDR  out  ADDR_WIDTH  write address.
- M_AXI_AWPROT  out  3  constant 3'b000.
- M_AXI_AWVALID  out  1  write address valid.
- M_AXI_AWREADY  in  1  write address ready.
- M_AXI_WDATA  out  32  write data.
- M_AXI_WSTRB  out  4  constant 4'hF.
- M_AXI_WVALID  out  1  write data valid.
- M_AXI_WREADY  in  1  write data ready.
- M_AXI_BRESP  in  2  write response.
- M_AXI_BVALID  in  1  write response valid.
- M_AXI_BREADY  out  1  write response ready.
- M_AXI_ARADDR  out  ADDR_WIDTH  read address.
- M_AXI_ARPROT  out  3  constant 3'b000.
- M_AXI_ARVALID  out  1  read address valid.
- M_AXI_ARREADY  in  1  read address ready.
- M_AXI_RDATA  in  32  read data.
- M_AXI_RRESP  in  2  read response.
- M_AXI_RVALID  in  1  read data valid.
- M_AXI_RREADY  out  1  read data ready.

Behaviour:
- Reset (ARESETN low, asynchronous):
  - All VALID/READY outputs, busy, done and error = 0; err_index = all-ones; address/data outputs = 0; state IDLE; idx = 0.
  - Reset asserted mid-transaction drops VALIDs immediately; no completion is reported.
- All outputs are registered.
- States and transitions:
  - IDLE: start=1 → latch cfg_table into a shadow register, idx=0, clear done/error, set busy → WR.
  - WR: AWVALID and WVALID assert 1 cycle after start (or after the previous entry), with AWADDR and WDATA from entry idx.
    - Each VALID deasserts independently on the cycle after its own handshake (VALID&READY).
    - AW-before-W, W-before-AW and same-cycle handshakes are all legal.
    - VALIDs never drop before their handshake.
    - When both handshakes are done → WR_RESP.
  - WR_RESP: BREADY=1.
    - On BVALID: BRESP≠2'b00 → record idx in err_index, error=1 → FIN.
    - Else if idx==NUM_ENTRIES-1 → RD (macro on) or FIN (macro off).
    - Else idx+1 → WR.
  - FIN: busy=0, done=1 → IDLE.
- start while busy: ignored.
- start in the same cycle that done rises: ignored.
- cfg_table changes during a sequence: no effect, because the table is shadowed.
- Latency, zero-wait-state slave, macro off: 3 cycles per entry (VALID, B, advance); done rises 3*NUM_ENTRIES+1 cycles after start.
- Only one outstanding transaction at any time.

Optional Feature:
- Macro: VIDEO_CFG_READBACK_EN.
- When defined:
  - After the last write, idx=0 → RD: ARVALID with ARADDR from entry idx, held until ARREADY → RD_DATA.
  - RD_DATA: RREADY=1; on RVALID, fail if RRESP≠2'b00 or RDATA≠entry data.
    - On failure: err_index=idx, error=1 → FIN.
    - Else advance idx, or go to FIN after the last entry.
- When not defined: the RD/RD_DATA states and comparator are absent; ARVALID and RREADY are tied to 0.

Test Plan:
- Table {0x0:0x1, 0x4:0x2, 0x8:0x3, 0xC:0x4}, zero-wait slave, start pulse → 4 writes in order, done=1, error=0, err_index=0x7 (all-ones); with readback, 4 reads return 1..4 and error=0.
- AWREADY delayed 5 cycles, WREADY immediate → WVALID drops after 1 cycle, AWVALID held 6 cycles with stable AWADDR; BREADY is not asserted before both handshakes complete.
- Slave returns BRESP=2'b10 on entry 2 → no write to 0xC, done=1, error=1, err_index=2.
- Readback build, slave corrupts RDATA for 0x4 to 0x5 → done=1, error=1, err_index=1, no read of 0x8.
- ARESETN pulsed low while AWVALID=1 on entry 1 → VALIDs drop asynchronously, busy=0, done=0; a subsequent start reruns from entry 0.
- start pulsed again while busy, and cfg_table altered mid-run → the sequence is unaffected; exactly 4 writes carrying the original values.
